leg_solver: RTL
===============

LEG_SOLVER -- requirements
Module: leg_solver

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand/result bit width.
REQ-002 SHALL have port: clk  input  1  single rising-edge clock.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port: r_in  input  WIDTH  magnitude (hypotenuse) r, unsigned.
REQ-006 SHALL have port: x_in  input  WIDTH  known leg x, unsigned.
REQ-007 SHALL have port: busy  output  1  high whenever state != IDLE.
REQ-008 SHALL have port: done  output  1  one-cycle pulse; y_out/err valid.
REQ-009 SHALL have port: y_out  output  WIDTH  floor(sqrt(r^2 - x^2)), registered.
REQ-010 SHALL have port: err  output  1  set when x > r, registered.

Function
REQ-011 SHALL implement FSM states IDLE, SQUARE, DIFF, SQRT, DONE.
REQ-012 IDLE: on edge with start=1, SHALL latch r_in/x_in and go to SQUARE; start=0 stays in IDLE.
REQ-013 SQUARE: SHALL register r^2 and x^2 (2*WIDTH bits each, no truncation), then go to DIFF.
REQ-014 DIFF: if x^2 > r^2, SHALL set internal num=0 and error flag=1, else num=r^2-x^2 and flag=0; res=0, bit=1<<(2*WIDTH-2), iteration count=WIDTH; go to SQRT.
REQ-015 SQRT: per edge, if num >= res+bit then num-=res+bit, res=(res>>1)+bit, else res=res>>1; bit>>=2; after exactly WIDTH iterations go to DONE.
REQ-016 SQRT SHALL run the full WIDTH iterations regardless of operand value (no leading-bit skip), giving fixed latency.
REQ-017 DONE: SHALL load y_out=res[WIDTH-1:0], err=flag, done=1 for this single cycle, then return to IDLE.
REQ-018 done SHALL rise exactly WIDTH+3 edges after the edge sampling start (11 for WIDTH=8).
REQ-019 y_out and err SHALL hold their values from one DONE until the next DONE.
REQ-020 start while busy (including the DONE cycle) SHALL be ignored, with no queuing.
REQ-021 r_in/x_in changes after acceptance SHALL not affect the result in flight.
REQ-022 x == r SHALL yield y_out=0, err=0; x > r SHALL yield y_out=0, err=1.

Reset
REQ-023 rst=1 at an edge SHALL force state IDLE, busy=0, done=0, y_out=0, err=0, and clear all internal registers.
REQ-024 rst asserted mid-operation SHALL abort the computation with no done pulse; the next start after rst deasserts SHALL compute normally.
REQ-025 rst SHALL take priority over start on the same edge.

Structure
REQ-026 SHALL define state enum and WIDTH default in shared package leg_solver_pkg.
REQ-027 SHALL instantiate one combinational sub-module isqrt_step (inputs num,res,bit; outputs next num,res) used by SQRT.

Verification
REQ-028 r=5, x=3, start -> done at edge 11 with y_out=4, err=0.
REQ-029 r=255, x=254 -> y_out=22, err=0; r=255, x=0 -> y_out=255; r=0, x=0 -> y_out=0.
REQ-030 r=5, x=5 -> y_out=0, err=0; r=3, x=5 -> y_out=0, err=1.
REQ-031 start held high and inputs changed during busy -> exactly one done per accepted start; result matches the values latched at acceptance; back-to-back starts spaced 12 cycles apart.
REQ-032 rst pulsed during SQRT -> no done, all outputs 0; a subsequent r=13, x=5 request -> y_out=12.

Source files
------------

// File: rtl/leg_solver_pkg.sv
// Shared definitions for the leg_solver block: FSM states and default width.
package leg_solver_pkg;

  localparam int unsigned WIDTH_DEFAULT = 8;

  typedef enum logic [2:0] {
    StIdle,
    StSquare,
    StDiff,
    StSqrt,
    StDone
  } state_e;

endpackage

// File: rtl/leg_solver_isqrt_step.sv
// One iteration of the bit-by-bit integer square root (restoring form).
module isqrt_step #(
  parameter int unsigned NUM_W = 16
) (
  input  logic [NUM_W-1:0] num,
  input  logic [NUM_W-1:0] res,
  input  logic [NUM_W-1:0] sq_bit,
  output logic [NUM_W-1:0] num_next,
  output logic [NUM_W-1:0] res_next
);

  logic [NUM_W:0] trial;
  logic           take;

  // Compare against res+bit one bit wider so the sum can never wrap.
  always_comb begin
    trial = {1'b0, res} + {1'b0, sq_bit};
    take  = ({1'b0, num} >= trial);
    if (take) begin
      num_next = num - res - sq_bit;
      res_next = (res >> 1) + sq_bit;
    end else begin
      num_next = num;
      res_next = res >> 1;
    end
  end

endmodule

// File: rtl/leg_solver.sv
// Computes y = floor(sqrt(r^2 - x^2)) with fixed latency; flags x > r.
module leg_solver
  import leg_solver_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] r_in,
  input  logic [WIDTH-1:0] x_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y_out,
  output logic             err
);

  localparam int unsigned NUM_W = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   r_q, r_d;
  logic [WIDTH-1:0]   x_q, x_d;
  logic [NUM_W-1:0]   rsq_q, rsq_d;
  logic [NUM_W-1:0]   xsq_q, xsq_d;
  logic [NUM_W-1:0]   num_q, num_d;
  logic [NUM_W-1:0]   res_q, res_d;
  logic [NUM_W-1:0]   bit_q, bit_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               flag_q, flag_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic               err_q, err_d;
  logic               done_q, done_d;

  logic [NUM_W-1:0]   r_ext, x_ext;
  logic [NUM_W-1:0]   step_num, step_res;

  isqrt_step #(
    .NUM_W (NUM_W)
  ) u_isqrt_step (
    .num      (num_q),
    .res      (res_q),
    .sq_bit   (bit_q),
    .num_next (step_num),
    .res_next (step_res)
  );

  // Zero-extend operands so the products keep all 2*WIDTH bits.
  always_comb begin
    r_ext = {{WIDTH{1'b0}}, r_q};
    x_ext = {{WIDTH{1'b0}}, x_q};
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    x_d     = x_q;
    rsq_d   = rsq_q;
    xsq_d   = xsq_q;
    num_d   = num_q;
    res_d   = res_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    flag_d  = flag_q;
    y_d     = y_q;
    err_d   = err_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          r_d     = r_in;
          x_d     = x_in;
          state_d = StSquare;
        end
      end
      StSquare: begin
        rsq_d   = r_ext * r_ext;
        xsq_d   = x_ext * x_ext;
        state_d = StDiff;
      end
      StDiff: begin
        if (xsq_q > rsq_q) begin
          num_d  = '0;
          flag_d = 1'b1;
        end else begin
          num_d  = rsq_q - xsq_q;
          flag_d = 1'b0;
        end
        res_d   = '0;
        bit_d   = {2'b01, {(NUM_W - 2){1'b0}}};
        cnt_d   = CNT_W'(WIDTH);
        state_d = StSqrt;
      end
      StSqrt: begin
        // Always runs all WIDTH iterations so latency is operand-independent.
        num_d = step_num;
        res_d = step_res;
        bit_d = bit_q >> 2;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        y_d     = res_q[WIDTH-1:0];
        err_d   = flag_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      r_q     <= '0;
      x_q     <= '0;
      rsq_q   <= '0;
      xsq_q   <= '0;
      num_q   <= '0;
      res_q   <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
      y_q     <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      x_q     <= x_d;
      rsq_q   <= rsq_d;
      xsq_q   <= xsq_d;
      num_q   <= num_d;
      res_q   <= res_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      y_q     <= y_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // Output drive.
  always_comb begin
    busy  = (state_q != StIdle);
    done  = done_q;
    y_out = y_q;
    err   = err_q;
  end

endmodule
